// File: rtl/f_pc_fd_reg_pkg.sv
// Shared constants and helpers for the fetch stage and F/D pipeline register.
package f_pc_fd_reg_pkg;

  // Reset PC and exception handler entry
  localparam logic [31:0] INIT_ADDR_DEF = 32'h0000_3000;
  localparam logic [31:0] TRAP_ADDR_DEF = 32'h0000_4180;

  // Legal instruction-memory window (inclusive on both ends)
  localparam logic [31:0] IM_BASE_DEF   = 32'h0000_3000;
  localparam logic [31:0] IM_LAST_DEF   = 32'h0000_6ffc;

  // Exception codes carried down the pipe
  localparam logic [4:0]  EXC_NONE      = 5'd0;
  localparam logic [4:0]  EXC_ADEL      = 5'd4;

  // Select codes driven by the next-PC selector that feeds NPC
  typedef enum logic [1:0] {
    NPC_SEQ    = 2'd0,
    NPC_BRANCH = 2'd1,
    NPC_JUMP   = 2'd2,
    NPC_JR     = 2'd3
  } npc_sel_e;

  // Fetch address error: misaligned word or outside the instruction window.
  // All compares are unsigned.
  function automatic logic fetch_adel(input logic [31:0] pc,
                                      input logic [31:0] base,
                                      input logic [31:0] last);
    fetch_adel = (pc[1:0] != 2'b00) || (pc < base) || (pc > last);
  endfunction

endpackage

// File: rtl/f_pc_fd_reg_fd_pipe_reg.sv
// F/D pipeline register: PC, instruction, exception code, delay-slot tag and
// valid bit of the instruction handed from fetch to decode.
module fd_pipe_reg
  import f_pc_fd_reg_pkg::*;
#(
  parameter logic [31:0] RESET_PC = INIT_ADDR_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic [31:0] f_pc,
  input  logic [31:0] f_instr,
  input  logic [4:0]  f_exc_code,
  input  logic        f_bd,
  output logic [31:0] d_pc,
  output logic [31:0] d_instr,
  output logic [4:0]  d_exc_code,
  output logic        d_bd,
  output logic        d_valid
);

  // Reset, then flush to a bubble tagged with the redirect PC, then load when enabled
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      d_pc       <= RESET_PC;
      d_instr    <= '0;
      d_exc_code <= EXC_NONE;
      d_bd       <= 1'b0;
      d_valid    <= 1'b0;
    end else if (flush) begin
      d_pc       <= flush_pc;
      d_instr    <= '0;
      d_exc_code <= EXC_NONE;
      d_bd       <= 1'b0;
      d_valid    <= 1'b0;
    end else if (en) begin
      d_pc       <= f_pc;
      d_instr    <= f_instr;
      d_exc_code <= f_exc_code;
      d_bd       <= f_bd;
      d_valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/f_pc_fd_reg.sv
// Fetch-stage state: PC register, fetch address check, and the redirect /
// stall priority that steers both the PC and the F/D pipeline register.
module f_pc_fd_reg
  import f_pc_fd_reg_pkg::*;
#(
  parameter logic [31:0] INIT_ADDR = INIT_ADDR_DEF,
  parameter logic [31:0] TRAP_ADDR = TRAP_ADDR_DEF,
  parameter logic [31:0] IM_BASE   = IM_BASE_DEF,
  parameter logic [31:0] IM_LAST   = IM_LAST_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] NPC,
  input  logic        stall,
  input  logic        IntReq,
  input  logic        D_eret,
  input  logic [31:0] EPC,
  input  logic        D_is_bj,
  input  logic [31:0] F_instr,
  output logic [31:0] F_PC,
  output logic [31:0] D_PC,
  output logic [31:0] D_instr,
  output logic [4:0]  D_ExcCode,
  output logic        D_BD,
  output logic        D_valid
);

  logic        f_exc;
  logic [4:0]  f_exc_code;
  logic [31:0] f_instr_gated;
  logic        fd_en;
  logic        fd_flush;
  logic [31:0] fd_flush_pc;

  // Fetch check and the control fed to the F/D register. A faulting fetch
  // carries a zero instruction so decode sees a harmless nop.
  always_comb begin
    f_exc         = fetch_adel(F_PC, IM_BASE, IM_LAST);
    f_exc_code    = f_exc ? EXC_ADEL : EXC_NONE;
    f_instr_gated = f_exc ? '0 : F_instr;
    fd_en         = !stall;
    // Interrupts flush through a stall; an eret only acts once unstalled.
    fd_flush      = IntReq || (!stall && D_eret);
    fd_flush_pc   = IntReq ? TRAP_ADDR : EPC;
  end

  // PC register: reset > interrupt > stall hold > eret > sequential NPC
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      F_PC <= INIT_ADDR;
    end else if (IntReq) begin
      F_PC <= TRAP_ADDR;
    end else if (stall) begin
      F_PC <= F_PC;
    end else if (D_eret) begin
      F_PC <= EPC;
    end else begin
      F_PC <= NPC;
    end
  end

  fd_pipe_reg #(
    .RESET_PC (INIT_ADDR)
  ) u_fd_pipe_reg (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (fd_en),
    .flush      (fd_flush),
    .flush_pc   (fd_flush_pc),
    .f_pc       (F_PC),
    .f_instr    (f_instr_gated),
    .f_exc_code (f_exc_code),
    .f_bd       (D_is_bj),
    .d_pc       (D_PC),
    .d_instr    (D_instr),
    .d_exc_code (D_ExcCode),
    .d_bd       (D_BD),
    .d_valid    (D_valid)
  );

endmodule
